mem_trans_cont: RTL
===================

# mem_trans_cont

Parametrised bank of toggle (transition) counters for power estimation, replacing the asynchronous latch-style counter memory. Each channel watches one bit of a monitored vector and counts its 0→1 and 1→0 transitions every clock. Counters are read and written through a synchronous address/data port, so the testbench power-calculation flow (`CALCULOPOTENCIA`) can sample and preload them without combinational loops.

## Interface
- NUM_CNTR, 12: number of counter channels (N, not N-1).
- NDIR, 4: address width in bits; must satisfy 2^NDIR ≥ NUM_CNTR.
- ANCHO, 32: counter width, 1..32; read data zero-extended to 32 bits.
- MODO_SAT, 0: 0 = counter wraps to 0 after all-ones; 1 = counter holds at all-ones.
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  synchronous, active-low reset.
- habilitar  in  1  global count enable; 0 freezes all counters, sampling continues.
- senal  in  NUM_CNTR  monitored signals, one bit per channel.
- dir  in  NDIR  counter address.
- LE  in  1  1 = read, 0 = write (same polarity as earlier generation).
- dato_in  in  32  write data; low ANCHO bits used.
- dato_out  out  32  registered read data.
- desborde  out  NUM_CNTR  sticky per-channel overflow flags.

## Operation
- Reset (reset_L=0 at a rising edge): all counters 0, desborde 0, dato_out 0, previous-sample register 0, `cebado` flag 0.
- Priming: first cycle after reset released only loads senal into previous-sample register and sets cebado=1; no counts. Prevents counting reset-induced edges.
- Toggle detect per channel i: trans[i] = senal[i] XOR prev[i] when cebado=1; prev updated every cycle regardless of habilitar.
- Count: if habilitar=1 and trans[i]=1, counter[i] increments by 1.
  - MODO_SAT=0: all-ones + 1 → 0, desborde[i] set.
  - MODO_SAT=1: all-ones stays all-ones, desborde[i] set on the attempted increment.
- Write (LE=0): counter[dir] ← dato_in[ANCHO-1:0]; desborde[dir] cleared. Write wins over a same-cycle toggle on that channel (the toggle is dropped, not added). Other channels count normally.
- Read (LE=1): dato_out ← zero-extended counter[dir] value before this edge's update.
- dir ≥ NUM_CNTR: reads return 0; writes ignored, no state change.
- During LE=0, dato_out holds its previous value.
- desborde is sticky: cleared only by reset or by a write to that channel.

## Timing
- Toggle on senal sampled at edge k is reflected in the counter at edge k (counter visible to a read issued at edge k+1).
- Read latency: 1 cycle (dir/LE presented before edge k, dato_out valid after edge k).
- Write latency: 1 cycle; a read of the same address the next cycle returns the written value (plus any toggle of that next cycle is not yet included).
- Reset mid-operation: takes effect at the next rising edge, discards pending counts, re-enters priming.
- No combinational path from any input to any output.

## Structure
- Shared package `mem_trans_pkg`: MODO_WRAP=0 / MODO_SAT=1 constants, LEER=1 / ESCRIBIR=0 constants for LE.
- One sub-module `contador_trans`: single channel (prev bit, counter, sticky overflow, write-load, saturate/wrap), instantiated NUM_CNTR times via generate; top holds cebado, address decode, and read mux/register.

## Test plan
- Reset then priming: senal=all-ones during reset, release, hold senal → all counters read 0, desborde=0.
- Basic count: channel 2 toggled 5 times with habilitar=1, others static → read dir=2 gives 5, dir=0 gives 0.
- Enable gating: 3 toggles with habilitar=0 then 2 with habilitar=1 → count 2 (frozen toggles not retroactive).
- Wrap vs saturate, ANCHO=4: preload 15 then one toggle → MODO_SAT=0 reads 0, MODO_SAT=1 reads 15; desborde set in both; write 3 clears desborde.
- Write/toggle collision: write 7 to channel 1 in the same cycle channel 1 toggles → reads 7; channel 0 toggling same cycle increments normally.
- Out-of-range: NUM_CNTR=12, NDIR=4, write dir=13 then read dir=13 → 0, all counters unchanged.

Source files
------------

// File: rtl/mem_trans_cont_pkg.sv
// Shared constants and types for the transition-counter bank.
// Counting-mode selectors, read/write polarity of LE, and the priming state type.
package mem_trans_pkg;

    localparam int MODO_WRAP = 0;
    localparam int MODO_SAT  = 1;

    localparam logic LEER     = 1'b1;
    localparam logic ESCRIBIR = 1'b0;

    typedef enum logic {
        CEBANDO = 1'b0,
        ACTIVO  = 1'b1
    } estado_t;

endpackage

// File: rtl/mem_trans_cont_if.sv
// Synchronous address/data port of the transition-counter bank.
// The master side issues reads and writes; the slave side returns registered read data.
interface mem_trans_cont_if #(
    parameter int NDIR = 4
) ();

    logic [NDIR-1:0] dir;
    logic            LE;
    logic [31:0]     dato_in;
    logic [31:0]     dato_out;

    modport master (
        output dir,
        output LE,
        output dato_in,
        input  dato_out
    );

    modport slave (
        input  dir,
        input  LE,
        input  dato_in,
        output dato_out
    );

endinterface

// File: rtl/mem_trans_cont_contador_trans.sv
// One transition-counter channel: previous-sample bit, counter, and sticky overflow.
// A write to the channel takes priority over a toggle seen in the same cycle.
module contador_trans
    import mem_trans_pkg::*;
#(
    parameter int ANCHO    = 32,
    parameter int MODO_SAT = MODO_WRAP
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             cebado,
    input  logic             habilitar,
    input  logic             senal,
    input  logic             wr_en,
    input  logic [ANCHO-1:0] wr_dato,
    output logic [ANCHO-1:0] cuenta,
    output logic             desborde
);

    localparam logic [ANCHO-1:0] LLENO = '1;

    logic prev;
    logic toggle;

    assign toggle = cebado && (senal ^ prev);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            prev     <= 1'b0;
            cuenta   <= '0;
            desborde <= 1'b0;
        end else begin
            prev <= senal;
            if (wr_en) begin
                cuenta   <= wr_dato;
                desborde <= 1'b0;
            end else if (habilitar && toggle) begin
                if (cuenta == LLENO) begin
                    desborde <= 1'b1;
                    // saturating channels hold at all-ones, wrapping ones roll over to zero
                    cuenta   <= (MODO_SAT == mem_trans_pkg::MODO_SAT) ? cuenta : '0;
                end else begin
                    cuenta <= cuenta + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_trans_cont.sv
// Bank of NUM_CNTR toggle counters for power estimation, with a registered
// synchronous read/write port. Holds the priming state, address decode and read mux.
module mem_trans_cont
    import mem_trans_pkg::*;
#(
    parameter int NUM_CNTR = 12,
    parameter int NDIR     = 4,
    parameter int ANCHO    = 32,
    parameter int MODO_SAT = 0
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                habilitar,
    input  logic [NUM_CNTR-1:0] senal,
    mem_trans_cont_if.slave     bus,
    output logic [NUM_CNTR-1:0] desborde
);

    // state   | meaning
    // CEBANDO | first cycle after reset: load previous samples only, no counting
    // ACTIVO  | toggles are detected and counted

    estado_t estado, estado_sig;
    logic    cebado;

    logic [ANCHO-1:0]    cuentas [NUM_CNTR];
    logic [NUM_CNTR-1:0] wr_en;
    logic [31:0]         dato_rd;
    logic                unused_ok;

    assign unused_ok = ^bus.dato_in;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            estado <= CEBANDO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            CEBANDO: estado_sig = ACTIVO;
            ACTIVO:  estado_sig = ACTIVO;
            default: estado_sig = CEBANDO;
        endcase
    end

    always_comb begin
        cebado = (estado == ACTIVO);
    end

    // out-of-range addresses match no channel, so they read 0 and never write
    always_comb begin
        dato_rd = '0;
        wr_en   = '0;
        for (int i = 0; i < NUM_CNTR; i++) begin
            if (bus.dir == NDIR'(i)) begin
                dato_rd  = 32'(cuentas[i]);
                wr_en[i] = (bus.LE == ESCRIBIR);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            bus.dato_out <= '0;
        end else if (bus.LE == LEER) begin
            bus.dato_out <= dato_rd;
        end
    end

    for (genvar g = 0; g < NUM_CNTR; g++) begin : g_canal
        contador_trans #(
            .ANCHO    (ANCHO),
            .MODO_SAT (MODO_SAT)
        ) u_canal (
            .clk       (clk),
            .reset_L   (reset_L),
            .cebado    (cebado),
            .habilitar (habilitar),
            .senal     (senal[g]),
            .wr_en     (wr_en[g]),
            .wr_dato   (bus.dato_in[ANCHO-1:0]),
            .cuenta    (cuentas[g]),
            .desborde  (desborde[g])
        );
    end

endmodule
